// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and helpers for the raster generator.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_CLK_DIV  = 4;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Regions of one axis, in the order they occur along a line or frame.
  typedef enum logic [1:0] {
    REG_SYNC,
    REG_BACK,
    REG_ACTIVE,
    REG_FRONT
  } axis_region_e;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned axis_width(input int unsigned n);
    return (n < 2) ? 1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus registered sync/active/coordinate decode.
// The decode is computed from the next count so position and decode always
// change on the same edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FRONT  = DEF_H_FRONT,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BACK   = DEF_H_BACK,
  parameter logic        POL    = 1'b0,
  parameter int unsigned W      = axis_width(ACTIVE + FRONT + SYNC + BACK)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         sync_o,
  output logic         active_o,
  output logic [W-1:0] coord_o,
  output logic         wrap_o
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] BACK_START = W'(SYNC);
  localparam logic [W-1:0] ACT_START  = W'(SYNC + BACK);
  localparam logic [W-1:0] ACT_END    = W'(SYNC + BACK + ACTIVE - 1);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] coord_q, coord_d;
  logic         sync_q, sync_d;
  logic         active_q, active_d;
  axis_region_e region_d;

  // Wrap is qualified by the increment so the next axis only sees real wraps.
  assign wrap_o = inc_i && (count_q == LAST);

  // Next position and the decode of that next position.
  always_comb begin
    count_d  = wrap_o ? '0 : count_q + 1'b1;
    region_d = REG_FRONT;
    if (count_d < BACK_START)     region_d = REG_SYNC;
    else if (count_d < ACT_START) region_d = REG_BACK;
    else if (count_d <= ACT_END)  region_d = REG_ACTIVE;
    sync_d   = (region_d == REG_SYNC) ? POL : ~POL;
    active_d = (region_d == REG_ACTIVE);
    coord_d  = active_d ? (count_d - ACT_START) : '0;
  end

  // Position and decode advance together on each increment; reset is position 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      sync_q   <= POL;
      active_q <= 1'b0;
      coord_q  <= '0;
    end else if (inc_i) begin
      count_q  <= count_d;
      sync_q   <= sync_d;
      active_q <= active_d;
      coord_q  <= coord_d;
    end
  end

  assign count_o  = count_q;
  assign sync_o   = sync_q;
  assign active_o = active_q;
  assign coord_o  = coord_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-tick divider, horizontal and
// vertical axis counters, line/frame strobes and a completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned HW       = axis_width(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  parameter int unsigned VW       = axis_width(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          pix_tick_o,
  output logic [HW-1:0] h_count_o,
  output logic [VW-1:0] v_count_o,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          bright_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic [15:0]   frame_count_o
);

  localparam int unsigned   DW       = axis_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic          h_wrap, v_wrap;
  logic          h_active, v_active;
  logic [HW-1:0] h_coord;
  logic [VW-1:0] v_coord;
  logic          line_start_q, frame_start_q;
  logic [15:0]   frame_count_q, frame_count_d;

  // The tick is the last divider phase of an enabled cycle; dropping en_i
  // suppresses it immediately so a frozen generator never shows a tick.
  assign tick = en_i && (div_q == DIV_LAST);

  // Divider phase advances only while enabled, so a pause resumes mid-phase.
  always_comb begin
    div_d = div_q;
    if (en_i) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Divider phase register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) div_q <= '0;
    else         div_q <= div_d;
  end

  // Completed frames count on the same edge the vertical axis wraps.
  always_comb begin
    frame_count_d = v_wrap ? frame_count_q + 16'd1 : frame_count_q;
  end

  // Strobes last exactly the one cycle after a wrap edge; reset never makes one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      frame_count_q <= frame_count_d;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HS_POL),
    .W      (HW)
  ) u_h_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (tick),
    .count_o  (h_count_o),
    .sync_o   (h_sync_o),
    .active_o (h_active),
    .coord_o  (h_coord),
    .wrap_o   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VS_POL),
    .W      (VW)
  ) u_v_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (h_wrap),
    .count_o  (v_count_o),
    .sync_o   (v_sync_o),
    .active_o (v_active),
    .coord_o  (v_coord),
    .wrap_o   (v_wrap)
  );

  // Coordinates are only meaningful inside the active area of both axes.
  assign bright_o      = h_active & v_active;
  assign x_o           = bright_o ? h_coord : '0;
  assign y_o           = bright_o ? v_coord : '0;
  assign pix_tick_o    = tick;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int hpol; int vpol; int div;
  } cfg_t;

  typedef struct packed {
    logic        tick;
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        br;
    logic [15:0] x;
    logic [15:0] y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  // 0: defaults, 1: default timing undivided, 2: tiny HS_POL=1, 3: tiny divided VS_POL=1
  function automatic cfg_t cfg(input int i);
    cfg_t c;
    case (i)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 4};
      1:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
      2:       c = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 1};
      default: c = '{6, 2, 3, 1, 3, 1, 2, 2, 0, 1, 3};
    endcase
    return c;
  endfunction

  // Expected outputs from the number of enabled cycles since reset release.
  function automatic obs_t model(input int i, input longint e, input logic en,
                                 input logic prev);
    cfg_t   c  = cfg(i);
    longint ht = c.ha + c.hf + c.hs + c.hb;
    longint vt = c.va + c.vf + c.vs + c.vb;
    longint n  = e / c.div;
    longint h  = n % ht;
    longint v  = (n / ht) % vt;
    logic   hin = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha);
    logic   vin = (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
    obs_t   o;
    o.tick = en && ((e % c.div) == c.div - 1);
    o.h    = 16'(h);
    o.v    = 16'(v);
    o.hs   = (h < c.hs) ? (c.hpol != 0) : (c.hpol == 0);
    o.vs   = (v < c.vs) ? (c.vpol != 0) : (c.vpol == 0);
    o.br   = hin && vin;
    o.x    = o.br ? 16'(h - (c.hs + c.hb)) : 16'd0;
    o.y    = o.br ? 16'(v - (c.vs + c.vb)) : 16'd0;
    o.ls   = prev && (h == 0);
    o.fs   = prev && (h == 0) && (v == 0);
    o.fc   = 16'(n / (ht * vt));
    return o;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic en_d, en_f, en_s, en_m;
  logic rand_on;

  logic pt0, hs0, vs0, br0, ls0, fs0; logic [9:0] h0, v0, x0, y0; logic [15:0] fc0;
  logic pt1, hs1, vs1, br1, ls1, fs1; logic [9:0] h1, v1, x1, y1; logic [15:0] fc1;
  logic pt2, hs2, vs2, br2, ls2, fs2; logic [3:0] h2, x2; logic [2:0] v2, y2; logic [15:0] fc2;
  logic pt3, hs3, vs3, br3, ls3, fs3; logic [3:0] h3, x3; logic [2:0] v3, y3; logic [15:0] fc3;

  int     checks = 0;
  int     errors = 0;
  longint e_cnt [4];
  logic   prev_adv [4];
  int     k, cnt;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_d), .pix_tick_o(pt0),
    .h_count_o(h0), .v_count_o(v0), .h_sync_o(hs0), .v_sync_o(vs0),
    .bright_o(br0), .x_o(x0), .y_o(y0), .line_start_o(ls0),
    .frame_start_o(fs0), .frame_count_o(fc0));

  vga_timing_gen #(.CLK_DIV(1)) dut_f (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_f), .pix_tick_o(pt1),
    .h_count_o(h1), .v_count_o(v1), .h_sync_o(hs1), .v_sync_o(vs1),
    .bright_o(br1), .x_o(x1), .y_o(y1), .line_start_o(ls1),
    .frame_start_o(fs1), .frame_count_o(fc1));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_s), .pix_tick_o(pt2),
    .h_count_o(h2), .v_count_o(v2), .h_sync_o(hs2), .v_sync_o(vs2),
    .bright_o(br2), .x_o(x2), .y_o(y2), .line_start_o(ls2),
    .frame_start_o(fs2), .frame_count_o(fc2));

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3)
  ) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_m), .pix_tick_o(pt3),
    .h_count_o(h3), .v_count_o(v3), .h_sync_o(hs3), .v_sync_o(vs3),
    .bright_o(br3), .x_o(x3), .y_o(y3), .line_start_o(ls3),
    .frame_start_o(fs3), .frame_count_o(fc3));

  function automatic logic en_of(input int i);
    case (i)
      0:       return en_d;
      1:       return en_f;
      2:       return en_s;
      default: return en_m;
    endcase
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model state: enabled cycles since reset and whether the last edge advanced.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        e_cnt[i]    = 0;
        prev_adv[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        prev_adv[i] = en_of(i) && ((e_cnt[i] % cfg(i).div) == cfg(i).div - 1);
        if (en_of(i)) e_cnt[i] = e_cnt[i] + 1;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    obs_t a [4];
    obs_t x;
    a[0] = '{pt0, 16'(h0), 16'(v0), hs0, vs0, br0, 16'(x0), 16'(y0), ls0, fs0, fc0};
    a[1] = '{pt1, 16'(h1), 16'(v1), hs1, vs1, br1, 16'(x1), 16'(y1), ls1, fs1, fc1};
    a[2] = '{pt2, 16'(h2), 16'(v2), hs2, vs2, br2, 16'(x2), 16'(y2), ls2, fs2, fc2};
    a[3] = '{pt3, 16'(h3), 16'(v3), hs3, vs3, br3, 16'(x3), 16'(y3), ls3, fs3, fc3};
    for (int i = 0; i < 4; i++) begin
      x = model(i, e_cnt[i], en_of(i), prev_adv[i]);
      checks++;
      if (a[i] !== x) begin
        errors++;
        $display("FAIL cmp_dut%0d t=%0t got=%h expected=%h", i, $time, a[i], x);
      end
    end
  end

  // Random run-enable for the small divided instance.
  initial begin
    en_m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      en_m = rand_on && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_n = 1'b0; rand_on = 1'b0;
    en_d = 1'b0; en_f = 1'b0; en_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h", h0, 0);
    chk("rst_v", v0, 0);
    chk("rst_hsync", hs0, 0);
    chk("rst_vsync", vs0, 0);
    chk("rst_bright", br0, 0);
    chk("rst_hsync_pol1", hs2, 1);
    rst_n = 1'b1; en_d = 1'b1; en_f = 1'b1; en_s = 1'b1; rand_on = 1'b1;

    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (pt0) break;
    end
    chk("first_tick_cycle", k, 4);
    @(posedge clk); #1;
    chk("h_after_first_tick", h0, 1);

    // Freeze mid-phase at hCount 300.
    for (k = 0; k < 3000 && h0 != 10'd300; k++) @(negedge clk);
    chk("reach_h300", h0, 300);
    repeat (2) @(negedge clk);
    #1 en_d = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (pt0) cnt++;
    end
    chk("freeze_h", h0, 300);
    chk("freeze_ticks", cnt, 0);
    #1 en_d = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (pt0) break;
    end
    chk("resume_phase", k, 1);
    chk("resume_h", h0, 300);

    // Active-area edges on the undivided default instance.
    for (k = 0; k < 40000 && !(v1 == 10'd35 && h1 == 10'd144); k++) @(negedge clk);
    chk("bright_start_bright", br1, 1);
    chk("bright_start_x", x1, 0);
    chk("bright_start_y", y1, 0);
    for (k = 0; k < 1000 && h1 != 10'd783; k++) @(negedge clk);
    chk("last_x", x1, 639);
    @(negedge clk);
    chk("after_active_h", h1, 784);
    chk("after_active_bright", br1, 0);
    for (k = 0; k < 1000 && h1 != 10'd799; k++) @(negedge clk);
    @(negedge clk);
    chk("line_start", ls1, 1);
    chk("line_start_h", h1, 0);

    // Frame period and sync polarity on the tiny instance.
    for (k = 0; k < 300 && !fs2; k++) @(negedge clk);
    chk("tiny_frame_seen", fs2, 1);
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (fs2) break;
    end
    chk("tiny_frame_period", k, 98);
    for (k = 0; k < 50 && h2 != 4'd1; k++) @(negedge clk);
    chk("tiny_hsync_h1", hs2, 1);
    @(negedge clk);
    chk("tiny_hsync_h2", hs2, 0);

    // Asynchronous reset mid-cycle at hCount 500.
    for (k = 0; k < 5000 && h0 != 10'd500; k++) @(negedge clk);
    chk("reach_h500", h0, 500);
    #2;
    rst_n = 1'b0; rand_on = 1'b0;
    en_d = 1'b0; en_f = 1'b0; en_s = 1'b0;
    #1;
    chk("arst_h", h0, 0);
    chk("arst_hsync", hs0, 0);
    chk("arst_v_f", v1, 0);
    chk("arst_fc_s", fc2, 0);
    chk("arst_hsync_s", hs2, 1);
    chk("arst_tick", pt0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; en_d = 1'b1; en_f = 1'b1; en_s = 1'b1; rand_on = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(ls0) + int'(fs0) + int'(ls1) + int'(fs1) + int'(ls2) + int'(fs2);
    end
    chk("no_strobe_after_release", cnt, 0);

    repeat (3000) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
